cpu_trap_ctrl: RTL
==================

// Module: cpu_trap_ctrl
// PURPOSE
//  Sequences the single-ported CSR file for trap entry and MRET, and shares its one read/write port with
//  Zicsr instructions. On a trap it writes mepc and mcause, fetches mtvec and emits a PC redirect.
//  On MRET it fetches mepc and emits a redirect. Sits between the W/D stages, hazard unit and CSR file.
// PARAMETERS
//  MTVEC_ADDR   12'h305  CSR address of mtvec
//  MEPC_ADDR    12'h341  CSR address of mepc
//  MCAUSE_ADDR  12'h342  CSR address of mcause
// PORTS
//  clk              in   1   clock, all state on posedge
//  rst              in   1   synchronous, active-high reset
//  instr_raddr      in   12  Zicsr read address (decode)
//  instr_rdata      out  32  Zicsr read data (passthrough of csr_rdata in IDLE, else 0)
//  instr_we         in   1   Zicsr write request (writeback)
//  instr_waddr      in   12  Zicsr write address
//  instr_wdata      in   32  Zicsr write data
//  trap_req         in   1   exception raised by the instruction in W
//  trap_pc          in   32  PC of the trapping instruction
//  trap_cause       in   32  mcause value
//  mret_req         in   1   MRET retiring in W
//  csr_raddr        out  12  to CSR file raddr
//  csr_rdata        in   32  from CSR file rdata (combinational)
//  csr_waddr        out  12  to CSR file waddr
//  csr_wdata        out  32  to CSR file wdata
//  csr_wenable      out  1   to CSR file wenable
//  flush            out  1   one-cycle pulse: kill all younger instructions
//  stall            out  1   freeze fetch..W while sequencing
//  redirect_valid   out  1   one-cycle pulse: load redirect_pc into PC
//  redirect_pc      out  32  new PC, low two bits always 0
// BEHAVIOUR
//  - FSM states: IDLE, W_CAUSE, RD_TVEC, RD_EPC, REDIRECT. Registers: state, cause_q[31:0], pc_q[31:0].
//  - Reset: state=IDLE, cause_q=0, pc_q=0. While rst=1: csr_wenable=0, flush=0, stall=0, redirect_valid=0,
//    redirect_pc=0. Reset mid-sequence abandons it; no further CSR writes.
//  - IDLE, priority trap_req > mret_req > instr_we:
//    . trap_req: csr_wenable=1, waddr=MEPC_ADDR, wdata={trap_pc[31:2],2'b00}. Set flush=1, cause_q<=trap_cause,
//      next W_CAUSE. A simultaneous instr_we is dropped because the trapping instruction never commits.
//    . mret_req (no trap): flush=1, next RD_EPC. A simultaneous instr_we is dropped.
//    . else: csr_w* = instr_w* (wenable = instr_we). csr_raddr = instr_raddr. stall=0.
//  - W_CAUSE: wenable=1, waddr=MCAUSE_ADDR, wdata=cause_q, next RD_TVEC.
//  - RD_TVEC: raddr=MTVEC_ADDR, pc_q<={csr_rdata[31:2],2'b00}, next REDIRECT. Direct mode only.
//  - RD_EPC: raddr=MEPC_ADDR, pc_q<={csr_rdata[31:2],2'b00}, next REDIRECT.
//  - REDIRECT: redirect_valid=1, redirect_pc=pc_q, next IDLE.
//  - Outside IDLE: stall=1, the instr_* interface is ignored, instr_rdata=0, and trap_req/mret_req are ignored.
//    When not in IDLE, csr_raddr=0 except in RD_TVEC/RD_EPC.
//  - Latency from the accept cycle (cycle 0):
//    . trap: mepc write at c0, mcause write at c1, mtvec read at c2, redirect_valid at c3.
//    . mret: mepc read at c1, redirect_valid at c2.
//  - stall is 0 in the accept cycle; flush covers that cycle.
//  - redirect_pc holds pc_q in every state but is meaningful only while redirect_valid=1.
//  - All outputs are combinational from state and inputs. No internal counter wraps.
// STRUCTURE
//  - CSR addresses stay in the shared cpu_csr_file.vh `defines (`CSR_MTVEC, `CSR_MEPC, add `CSR_MCAUSE).
//    Parameter defaults bind to these.
//  - State encodings go in cpu_trap_ctrl.vh as `TRAP_ST_*.
//  - No sub-module: one next-state always @(*) block and one posedge register block. The CSR file gains mcause.
// TESTING
//  1. Idle passthrough: instr_we=1, waddr=MEPC, wdata=32'h100 -> csr_wenable=1 same cycle, stall=0, flush=0;
//     instr_raddr=MEPC reads back 32'h100.
//  2. Trap: mtvec=32'h80, trap_req, trap_pc=32'h44, cause=2 ->
//     c0 flush=1, mepc written 32'h44; c1 mcause=2; c3 redirect_valid=1, redirect_pc=32'h80; stall=1 for c1..c3.
//  3. MRET: mepc=32'h47 -> c0 flush=1; c2 redirect_valid=1, redirect_pc=32'h44; no CSR write occurs.
//  4. Simultaneous trap_req+mret_req+instr_we(waddr=MTVEC, wdata=32'hFF) -> trap sequence runs,
//     mtvec unchanged, mret ignored.
//  5. trap_req pulsed in c1 and c2 of a sequence -> ignored; exactly one redirect, mcause from first trap.
//  6. rst=1 in W_CAUSE -> mcause not written, no redirect; after release instr writes pass in first cycle.

Source files
------------

// File: rtl/cpu_trap_ctrl_pkg.sv
// Shared definitions for the trap/MRET sequencer: CSR addresses, FSM states
// and the PC alignment helper.
package cpu_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_CAUSE,
        ST_RD_TVEC,
        ST_RD_EPC,
        ST_REDIRECT
    } trap_state_e;

    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_trap_ctrl.sv
// Trap entry / MRET sequencer that time-shares the single CSR read/write port
// with Zicsr instructions and produces the flush, stall and PC redirect.
module cpu_trap_ctrl
    import cpu_trap_ctrl_pkg::*;
#(
    parameter logic [11:0] MTVEC_ADDR  = CSR_MTVEC,
    parameter logic [11:0] MEPC_ADDR   = CSR_MEPC,
    parameter logic [11:0] MCAUSE_ADDR = CSR_MCAUSE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] instr_raddr,
    output logic [31:0] instr_rdata,
    input  logic        instr_we,
    input  logic [11:0] instr_waddr,
    input  logic [31:0] instr_wdata,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_req,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        csr_wenable,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    trap_state_e state, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d        = state;
        cause_d        = cause_q;
        pc_d           = pc_q;
        instr_rdata    = '0;
        csr_raddr      = '0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        csr_wenable    = 1'b0;
        flush          = 1'b0;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = pc_q;

        case (state)
            ST_IDLE: begin
                stall       = 1'b0;
                csr_raddr   = instr_raddr;
                instr_rdata = csr_rdata;
                // The trapping or returning instruction never commits, so its
                // Zicsr write is dropped rather than queued.
                if (trap_req) begin
                    csr_wenable = 1'b1;
                    csr_waddr   = MEPC_ADDR;
                    csr_wdata   = align4(trap_pc);
                    flush       = 1'b1;
                    cause_d     = trap_cause;
                    state_d     = ST_W_CAUSE;
                end else if (mret_req) begin
                    flush   = 1'b1;
                    state_d = ST_RD_EPC;
                end else begin
                    csr_wenable = instr_we;
                    csr_waddr   = instr_waddr;
                    csr_wdata   = instr_wdata;
                end
            end
            ST_W_CAUSE: begin
                csr_wenable = 1'b1;
                csr_waddr   = MCAUSE_ADDR;
                csr_wdata   = cause_q;
                state_d     = ST_RD_TVEC;
            end
            ST_RD_TVEC: begin
                // Direct mode only: the vector base is the handler address.
                csr_raddr = MTVEC_ADDR;
                pc_d      = align4(csr_rdata);
                state_d   = ST_REDIRECT;
            end
            ST_RD_EPC: begin
                csr_raddr = MEPC_ADDR;
                pc_d      = align4(csr_rdata);
                state_d   = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset silences every pipeline-visible control, whatever the state.
        if (rst) begin
            csr_wenable    = 1'b0;
            flush          = 1'b0;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state   <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

endmodule
